// File: rtl/mac8_accumulate.sv
// Pipelined multiply-accumulate stage: vm8bit products summed LEN at a time.
// Optional macro MAC8_SATURATE_EN clamps the accumulator instead of wrapping.

module vm8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic c1;
    c1 = (x[1] & y[0]) & (x[0] & y[1]);
    return {(x[1] & y[1]) & c1, (x[1] & y[1]) ^ c1,
            (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction

  // Urdhva-tiryagbhyam: four half-width crosswise products, shifted and summed
  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vm2(x[1:0], y[1:0]);
    q1 = vm2(x[3:2], y[1:0]);
    q2 = vm2(x[1:0], y[3:2]);
    q3 = vm2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  logic [7:0] r0, r1, r2, r3;

  always_comb begin
    r0 = vm4(a[3:0], b[3:0]);
    r1 = vm4(a[7:4], b[3:0]);
    r2 = vm4(a[3:0], b[7:4]);
    r3 = vm4(a[7:4], b[7:4]);
    p  = {8'b0, r0} + {4'b0, r1, 4'b0} + {4'b0, r2, 4'b0} + {r3, 8'b0};
  end
endmodule

module mac8_accumulate #(
  parameter int ACC_W = 20,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);
  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       a_q, b_q, cnt;
  logic             v1, v2, ovf_q;
  logic [15:0]      prod_q, prod_w;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_w;
  logic             accept, last_in, last_prod, handshake;

  vm8bit u_mul (.a(a_q), .b(b_q), .p(prod_w));

  assign accept    = in_valid & in_ready;
  assign last_in   = accept && (cnt == 8'(LEN - 1));
  // In DRAIN nothing new is accepted, so the last product is the one in S2 with S1 empty
  assign last_prod = (state == DRAIN) && v2 && !v1;
  assign handshake = (state == DONE) && out_ready;
  assign sum_w     = {1'b0, acc} + (ACC_W + 1)'(prod_q);

  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last_in)   state_nxt = DRAIN;
      DRAIN:   if (last_prod) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
    if (clear) state_nxt = ACC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt      <= '0;
      acc      <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      in_ready <= (state_nxt == ACC);
      v1       <= accept;
      v2       <= v1;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (v1) prod_q <= prod_w;
      if (handshake)   cnt <= '0;
      else if (accept) cnt <= cnt + 8'd1;
      if (handshake)   busy <= 1'b0;
      else if (accept) busy <= 1'b1;
      if (handshake) begin
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (v2) begin
`ifdef MAC8_SATURATE_EN
        if (sum_w[ACC_W]) begin
          acc   <= '1;
          ovf_q <= 1'b1;
        end else begin
          acc <= sum_w[ACC_W-1:0];
        end
`else
        acc <= sum_w[ACC_W-1:0];
        if (sum_w[ACC_W]) ovf_q <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mac8_accumulate.sv
// Directed bench for mac8_accumulate: three instances (default, LEN=3, ACC_W=17/LEN=4)
// share one stimulus bus, selected by sel; observed outputs are muxed the same way.

module tb_mac8_accumulate;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  rdy, vld, ovf, bsy;
  logic [19:0] sum0, sum1;
  logic [16:0] sum2;
  logic        cur_ready, cur_valid, cur_ovf, cur_busy;
  logic [31:0] cur_sum;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  mac8_accumulate u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid && sel == 2'd0),
    .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b), .out_valid(vld[0]),
    .out_ready(out_ready && sel == 2'd0), .out_sum(sum0), .out_ovf(ovf[0]), .busy(bsy[0]));

  mac8_accumulate #(.ACC_W(20), .LEN(3)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid && sel == 2'd1),
    .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b), .out_valid(vld[1]),
    .out_ready(out_ready && sel == 2'd1), .out_sum(sum1), .out_ovf(ovf[1]), .busy(bsy[1]));

  mac8_accumulate #(.ACC_W(17), .LEN(4)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid && sel == 2'd2),
    .in_ready(rdy[2]), .in_a(in_a), .in_b(in_b), .out_valid(vld[2]),
    .out_ready(out_ready && sel == 2'd2), .out_sum(sum2), .out_ovf(ovf[2]), .busy(bsy[2]));

  assign cur_ready = rdy[sel];
  assign cur_valid = vld[sel];
  assign cur_ovf   = ovf[sel];
  assign cur_busy  = bsy[sel];
  assign cur_sum   = (sel == 2'd0) ? 32'(sum0) : (sel == 2'd1) ? 32'(sum1) : 32'(sum2);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!cur_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(cur_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic waitValid();
    int n = 0;
    while (!cur_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("valid_wait", 32'(cur_valid), 32'd1);
  endtask

  task automatic pulseOutReady();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(cur_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(cur_valid), 32'd0);
    checkOutput("rst_out_sum", cur_sum, 32'd0);
    checkOutput("rst_out_ovf", 32'(cur_ovf), 32'd0);
    checkOutput("rst_busy", 32'(cur_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_edge_ready", 32'(cur_ready), 32'd1);

    // Full-scale default group with latency check
    for (int i = 0; i < 8; i++) applyStimulus(8'd255, 8'd255);
    in_valid = 1'b0;
    checkOutput("lat_e0_valid", 32'(cur_valid), 32'd0);
    checkOutput("drain_ready", 32'(cur_ready), 32'd0);
    @(negedge clk);
    checkOutput("lat_e1_valid", 32'(cur_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_e2_valid", 32'(cur_valid), 32'd1);
    checkOutput("full_sum", cur_sum, 32'd520200);
    checkOutput("full_ovf", 32'(cur_ovf), 32'd0);

    // Output backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_sum_stable", cur_sum, 32'd520200);
    end
    checkOutput("bp_in_ready", 32'(cur_ready), 32'd0);
    checkOutput("bp_busy", 32'(cur_busy), 32'd1);
    checkOutput("bp_valid", 32'(cur_valid), 32'd1);
    pulseOutReady();
    checkOutput("hs_in_ready", 32'(cur_ready), 32'd1);
    checkOutput("hs_out_valid", 32'(cur_valid), 32'd0);
    checkOutput("hs_busy", 32'(cur_busy), 32'd0);
    checkOutput("hs_sum_cleared", cur_sum, 32'd0);

    // Abort: clear with two pairs in flight and a pair offered on the clear edge
    for (int i = 0; i < 3; i++) applyStimulus(8'd10, 8'd10);
    checkOutput("abort_partial", cur_sum, 32'd100);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_sum", cur_sum, 32'd0);
    checkOutput("abort_busy", 32'(cur_busy), 32'd0);
    checkOutput("abort_ready", 32'(cur_ready), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(8'd1, 8'd2);
    in_valid = 1'b0;
    waitValid();
    checkOutput("post_abort_sum", cur_sum, 32'd16);
    pulseOutReady();

    // Asynchronous reset mid-group, mid-period
    for (int i = 0; i < 4; i++) applyStimulus(8'd2, 8'd3);
    in_valid = 1'b0;
    checkOutput("pre_rst_partial", cur_sum, 32'd12);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_in_ready", 32'(cur_ready), 32'd0);
    checkOutput("arst_out_sum", cur_sum, 32'd0);
    checkOutput("arst_busy", 32'(cur_busy), 32'd0);
    checkOutput("arst_out_valid", 32'(cur_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("arst_first_edge_ready", 32'(cur_ready), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(8'd2, 8'd3);
    in_valid = 1'b0;
    waitValid();
    checkOutput("post_rst_sum", cur_sum, 32'd48);
    pulseOutReady();

    // Bubbles on the LEN=3 instance
    sel = 2'd1;
    applyStimulus(8'd3, 8'd5);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("bub_gap_ready", 32'(cur_ready), 32'd1);
    checkOutput("bub_gap_busy", 32'(cur_busy), 32'd1);
    applyStimulus(8'd0, 8'd200);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("bub_gap_valid", 32'(cur_valid), 32'd0);
    applyStimulus(8'd17, 8'd15);
    in_valid = 1'b0;
    waitValid();
    checkOutput("bub_sum", cur_sum, 32'd270);
    checkOutput("bub_ovf", 32'(cur_ovf), 32'd0);
    pulseOutReady();

    // Overflow on the ACC_W=17, LEN=4 instance
    sel = 2'd2;
    for (int i = 0; i < 4; i++) applyStimulus(8'd255, 8'd255);
    in_valid = 1'b0;
    waitValid();
`ifdef MAC8_SATURATE_EN
    checkOutput("ovf_sum", cur_sum, 32'd131071);
`else
    checkOutput("ovf_sum", cur_sum, 32'd129028);
`endif
    checkOutput("ovf_flag", 32'(cur_ovf), 32'd1);
    pulseOutReady();
    checkOutput("ovf_cleared", 32'(cur_ovf), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mac8_accumulate.md
# mac8_accumulate

Pipelined multiply-accumulate stage built around the team's 8-bit Vedic multiplier (`vm8bit`). It accepts a stream of 8-bit unsigned operand pairs over a valid/ready handshake and registers each pair into the multiplier. It accumulates LEN consecutive 16-bit products into one ACC_W-bit sum and presents the sum downstream over a second valid/ready handshake. It is the consumer stage directly after the multiplier, turning single products into dot-product results.

## Interface
- `ACC_W`, default 20: accumulator and result width. Legal range is 17..32.
- `LEN`, default 8: number of products summed per result. Legal range is 1..255.
- `clk` input, 1 bit: the single clock. Everything is on the rising edge.
- `rst` input, 1 bit: reset. Asynchronous and active-high.
- `clear` input, 1 bit: synchronous abort with the highest priority.
- `in_valid` input, 1 bit: the operand pair on `in_a` and `in_b` is valid.
- `in_ready` output, 1 bit: the block can accept an operand pair.
- `in_a` input, 8 bits: multiplicand, unsigned.
- `in_b` input, 8 bits: multiplier, unsigned.
- `out_valid` output, 1 bit: `out_sum` holds a completed result.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_sum` output, ACC_W bits: the accumulated sum.
- `out_ovf` output, 1 bit: sticky flag. The current sum exceeded 2^ACC_W−1.
- `busy` output, 1 bit: at least one accepted pair is still in the pipeline, or a result is pending.

## Operation
- **Accept.** A pair is accepted on a rising edge where `in_valid` and `in_ready` are both 1. `in_a`/`in_b` may change freely while `in_ready` is 0.
- **Pipeline.**
  - S1: operand registers load the accepted pair.
  - S2: the product register loads `vm8bit(a_q, b_q)`, 16 bits.
  - S3: the accumulator adds the zero-extended product.
  - A valid bit travels with each pair, so bubbles never add to the sum.
- **Term counter.** An 8-bit counter counts accepted pairs.
- **State machine:**
  - ACC: `in_ready` = 1. When the LEN-th pair is accepted, go to DRAIN. `in_ready` is 0 from the next cycle.
  - DRAIN: `in_ready` = 0. When the LEN-th product enters the accumulator, go to DONE. `out_valid` rises on that same edge.
  - DONE: `out_valid` = 1, and `out_sum`/`out_ovf` are held stable. When `out_ready` = 1, the handshake completes: clear the accumulator, counter and `out_ovf`, then return to ACC. `in_ready` = 1 in the following cycle.
- **Arithmetic.** All operands are unsigned. The sum carries out of ACC_W bits only when ACC_W < 16 + ceil(log2 LEN). When it does, `out_ovf` sets and stays set until the result handshake. Wrap or saturate behaviour is under Configuration.
- **clear.** When 1 on an edge:
  - All pipeline valid bits, the counter, the accumulator and `out_ovf` are zeroed, and the state becomes ACC.
  - A pair offered on the same edge is discarded.
  - `clear` overrides a pending `out_ready` handshake; the result is dropped.
- **Reset.** Asserting `rst` at any point, including mid-accumulation or in DONE, immediately forces the same state as `clear`.
- **Reset values.** All registered outputs are 0 while `rst` is high: `in_ready`, `out_valid`, `out_sum`, `out_ovf`, `busy`.

## Timing
- `in_ready` rises on the first rising edge after `rst` falls.
- Latency: if the last pair of a group is accepted on edge E, `out_valid` is 1 after edge E+2. Counting the accepting edge as the first, that is the third edge.
- Full throughput within a group: one pair per cycle.
- Minimum group period: LEN + 3 cycles. This is LEN accept cycles, 2 drain cycles and 1 DONE cycle with `out_ready` = 1.
- `out_valid` stays asserted until the output handshake edge. It drops after that edge.
- `busy` = 1 from the edge after the first accept until the output handshake edge.

## Configuration
- `MAC8_SATURATE_EN` defined: the accumulator clamps at 2^ACC_W−1 and holds there for the rest of the group. `out_ovf` still sets.
- `MAC8_SATURATE_EN` undefined: the accumulator wraps modulo 2^ACC_W, and `out_ovf` sets on the first carry-out.

## Test plan
1. **Full-scale default group.** Defaults; 8 pairs of (255, 255) back-to-back. Expect `out_sum` = 520200 and `out_ovf` = 0, with `out_valid` high after the 3rd edge counted from the last accept.
2. **Bubbles.** LEN = 3; pairs (3, 5), (0, 200), (17, 15) with 2-cycle gaps in `in_valid`. Expect `out_sum` = 270, and an accept only on cycles where `in_valid` = 1.
3. **Output backpressure.** Hold `out_ready` = 0 for 5 cycles in DONE. Expect `out_sum` stable, `in_ready` = 0 and `busy` = 1. Then pulse `out_ready`: the next cycle shows `in_ready` = 1 and `out_valid` = 0, and the next group starts from 0.
4. **Overflow.** ACC_W = 17, LEN = 4, all pairs (255, 255).
   - Without the macro: `out_sum` = 129028 (260100 mod 131072) and `out_ovf` = 1.
   - With `MAC8_SATURATE_EN`: `out_sum` = 131071 and `out_ovf` = 1.
5. **Abort.** Assert `clear` after 3 of 8 pairs of (10, 10), while 2 of them are still in the pipeline. Then send 8 pairs of (1, 2). Expect `out_sum` = 16.
6. **Asynchronous reset.** Assert `rst` mid-group and mid-clock-period. All outputs go to 0 immediately. After release, `in_ready` = 1 on the first edge, and a group of 8 × (2, 3) gives `out_sum` = 48.
